movo_receiver: RTL and testbench

//  Receive side of the 16-bit MOVO v2 link. Deserialises two signed 16-bit words (A, B) from the differential line
//  (clock, data A, data B, latch) driven by the movo_interface transmitter or by a SERVOLAND SVF driver.

---
 rtl/movo_receiver.sv | 173 +++++++++++++++++
 tb/tb_movo_receiver.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/movo_receiver.sv
// movo_receiver: receive side of the 16-bit MOVO v2 differential link.
// Latency: valid/frame_err assert in the cycle after edge k+SYNC_STAGES, where edge k first samples latch_in high.
// Backpressure: none; strobes are one-cycle pulses and value_A/value_B hold until the next good frame.
// Ports: clk/rst (sync active-high), enable, eight async line legs (clock, data A, data B, latch; p and n each),
//        value_A/value_B (last good words), valid and frame_err strobes, line_fault level.
module movo_receiver #(
  parameter int SYNC_STAGES  = 2,
  parameter int TIMEOUT      = 256,
  parameter int FAULT_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        clk_movo_in,
  input  logic        clk_movo_n_in,
  input  logic        data_A_in,
  input  logic        data_A_n_in,
  input  logic        data_B_in,
  input  logic        data_B_n_in,
  input  logic        latch_in,
  input  logic        latch_n_in,
  output logic [15:0] value_A,
  output logic [15:0] value_B,
  output logic        valid,
  output logic        frame_err,
  output logic        line_fault
);

  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam int FC_W = $clog2(FAULT_CYCLES + 1);
  localparam logic [4:0] CNT_FULL = 5'd16;
  localparam logic [4:0] CNT_SAT  = 5'd17;

  // Leg order inside each synchroniser word: {latch_n, latch, B_n, B, A_n, A, clk_n, clk}
  logic [7:0] line_raw;
  assign line_raw = {latch_n_in, latch_in, data_B_n_in, data_B_in,
                     data_A_n_in, data_A_in, clk_movo_n_in, clk_movo_in};

  logic [SYNC_STAGES-1:0][7:0] sync_q, sync_d;
  logic [7:0]                  line_s;

  logic            hist_clk_q, hist_clk_d;
  logic            hist_latch_q, hist_latch_d;
  logic [15:0]     shift_a_q, shift_a_d;
  logic [15:0]     shift_b_q, shift_b_d;
  logic [4:0]      bit_cnt_q, bit_cnt_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [FC_W-1:0] fault_cnt_q, fault_cnt_d;
  logic            line_fault_q, line_fault_d;
  logic [15:0]     value_a_q, value_a_d;
  logic [15:0]     value_b_q, value_b_d;
  logic            valid_q, valid_d;
  logic            frame_err_q, frame_err_d;

  logic       clk_fall, clk_edge, latch_rise, pair_bad;
  logic [4:0] cnt;

  assign line_s     = sync_q[SYNC_STAGES-1];
  assign clk_fall   = hist_clk_q & ~line_s[0];
  assign clk_edge   = hist_clk_q ^ line_s[0];
  assign latch_rise = ~hist_latch_q & line_s[6];
  assign pair_bad   = (line_s[0] == line_s[1]) | (line_s[2] == line_s[3]) |
                      (line_s[4] == line_s[5]) | (line_s[6] == line_s[7]);

  always_comb begin
    sync_d       = {sync_q[SYNC_STAGES-2:0], line_raw};
    hist_clk_d   = line_s[0];
    hist_latch_d = line_s[6];

    // Timeout counter restarts on either movo clock edge and parks at TIMEOUT.
    if (clk_edge) begin
      to_cnt_d = '0;
    end else if (to_cnt_q == TO_W'(TIMEOUT)) begin
      to_cnt_d = to_cnt_q;
    end else begin
      to_cnt_d = to_cnt_q + 1'b1;
    end

    // Fault detector: count consecutive cycles that disagree with the current
    // line_fault level; flip the level after FAULT_CYCLES of them.
    fault_cnt_d  = '0;
    line_fault_d = line_fault_q;
    if (pair_bad != line_fault_q) begin
      if (fault_cnt_q == FC_W'(FAULT_CYCLES - 1)) begin
        line_fault_d = ~line_fault_q;
      end else begin
        fault_cnt_d = fault_cnt_q + 1'b1;
      end
    end

    shift_a_d   = shift_a_q;
    shift_b_d   = shift_b_q;
    value_a_d   = value_a_q;
    value_b_d   = value_b_q;
    valid_d     = 1'b0;
    frame_err_d = 1'b0;
    cnt         = bit_cnt_q;

    if (clk_fall) begin
      shift_a_d = {shift_a_q[14:0], line_s[2]};
      shift_b_d = {shift_b_q[14:0], line_s[4]};
      if (bit_cnt_q != CNT_SAT) begin
        cnt = bit_cnt_q + 1'b1;
      end
    end

    // A stalled line drops the partial frame silently.
    if (to_cnt_q == TO_W'(TIMEOUT) && !clk_edge) begin
      cnt = '0;
    end

    // Latch is evaluated after the shift so a coincident 16th bit is included.
    if (latch_rise) begin
      if (cnt == CNT_FULL) begin
        value_a_d = shift_a_d;
        value_b_d = shift_b_d;
        valid_d   = 1'b1;
      end else begin
        frame_err_d = 1'b1;
      end
      cnt = '0;
    end

    if (!enable || line_fault_q) begin
      cnt         = '0;
      valid_d     = 1'b0;
      frame_err_d = 1'b0;
      value_a_d   = value_a_q;
      value_b_d   = value_b_q;
    end

    bit_cnt_d = cnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q       <= '0;
      hist_clk_q   <= 1'b0;
      hist_latch_q <= 1'b0;
      shift_a_q    <= '0;
      shift_b_q    <= '0;
      bit_cnt_q    <= '0;
      to_cnt_q     <= '0;
      fault_cnt_q  <= '0;
      line_fault_q <= 1'b0;
      value_a_q    <= '0;
      value_b_q    <= '0;
      valid_q      <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      hist_clk_q   <= hist_clk_d;
      hist_latch_q <= hist_latch_d;
      shift_a_q    <= shift_a_d;
      shift_b_q    <= shift_b_d;
      bit_cnt_q    <= bit_cnt_d;
      to_cnt_q     <= to_cnt_d;
      fault_cnt_q  <= fault_cnt_d;
      line_fault_q <= line_fault_d;
      value_a_q    <= value_a_d;
      value_b_q    <= value_b_d;
      valid_q      <= valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign value_A    = value_a_q;
  assign value_B    = value_b_q;
  assign valid      = valid_q;
  assign frame_err  = frame_err_q;
  assign line_fault = line_fault_q;

endmodule

// File: tb/tb_movo_receiver.sv
// tb_movo_receiver: scoreboard bench for movo_receiver.
// Latency: expectations queued at stimulus time, retired when valid/frame_err strobe.
// Backpressure: none; every strobe must match the head of the expectation queue.
module tb_movo_receiver;

  typedef struct {
    logic        fe;
    logic [15:0] a;
    logic [15:0] b;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        clk_movo_in, clk_movo_n_in, data_A_in, data_A_n_in;
  logic        data_B_in, data_B_n_in, latch_in, latch_n_in;
  logic [15:0] value_A, value_B;
  logic        valid, frame_err, line_fault;

  logic lc = 1'b0, la = 1'b0, lb = 1'b0, ll = 1'b0;
  logic tie_a = 1'b0;

  int   tests = 0;
  int   fails = 0;
  exp_t exp_q[$];

  movo_receiver #(.SYNC_STAGES(2), .TIMEOUT(256), .FAULT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .clk_movo_in(clk_movo_in), .clk_movo_n_in(clk_movo_n_in),
    .data_A_in(data_A_in), .data_A_n_in(data_A_n_in),
    .data_B_in(data_B_in), .data_B_n_in(data_B_n_in),
    .latch_in(latch_in), .latch_n_in(latch_n_in),
    .value_A(value_A), .value_B(value_B),
    .valid(valid), .frame_err(frame_err), .line_fault(line_fault)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic apply();
    clk_movo_in   = lc;  clk_movo_n_in = ~lc;
    data_A_in     = la;  data_A_n_in   = tie_a ? la : ~la;
    data_B_in     = lb;  data_B_n_in   = ~lb;
    latch_in      = ll;  latch_n_in    = ~ll;
  endtask

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // MSB first, data changes on rise, latch rises with the last fall.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input int nbits, input bit do_latch);
    for (int i = 0; i < nbits; i++) begin
      int idx;
      idx = 15 - i;
      lc = 1'b1;
      if (i == 0) ll = 1'b0;
      la = (idx >= 0) ? a[idx] : 1'b0;
      lb = (idx >= 0) ? b[idx] : 1'b0;
      apply();
      hold(4);
      lc = 1'b0;
      if (do_latch && i == nbits - 1) ll = 1'b1;
      apply();
      hold(4);
    end
  endtask

  task automatic push(input logic fe, input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    e.fe = fe; e.a = a; e.b = b;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      hold(1);
      n++;
    end
    check_eq({tag, "_drained"}, exp_q.size(), 0);
    hold(10);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (valid && frame_err) check_eq("valid_and_frame_err", 1, 0);
      if (valid || frame_err) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_strobe", {valid, frame_err}, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check_eq("strobe_kind", frame_err, e.fe);
          if (valid) begin
            check_eq("value_A", value_A, e.a);
            check_eq("value_B", value_B, e.b);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    apply();
    hold(4);
    check_eq("rst_value_A", value_A, 0);
    check_eq("rst_value_B", value_B, 0);
    check_eq("rst_valid", valid, 0);
    check_eq("rst_frame_err", frame_err, 0);
    check_eq("rst_line_fault", line_fault, 0);
    rst = 1'b0;
    enable = 1'b1;
    hold(10);

    // Single frame
    push(1'b0, 16'h1234, 16'hFFFE);
    send(16'h1234, 16'hFFFE, 16, 1'b1);
    drain("t1");

    // Back-to-back frames
    push(1'b0, 16'h8000, 16'h7FFF);
    send(16'h8000, 16'h7FFF, 16, 1'b1);
    push(1'b0, 16'h0000, 16'h0001);
    send(16'h0000, 16'h0001, 16, 1'b1);
    drain("t2");

    // Short and long frames
    push(1'b1, 16'h0, 16'h0);
    send(16'hAAAA, 16'h5555, 15, 1'b1);
    drain("t3_short");
    check_eq("t3_hold_A", value_A, 16'h0000);
    check_eq("t3_hold_B", value_B, 16'h0001);
    push(1'b1, 16'h0, 16'h0);
    send(16'hAAAA, 16'h5555, 18, 1'b1);
    drain("t3_long");
    check_eq("t3_hold_A2", value_A, 16'h0000);

    // Partial frame discarded by timeout
    send(16'hFFFF, 16'hFFFF, 8, 1'b0);
    hold(300);
    push(1'b0, 16'h00FF, 16'h0F0F);
    send(16'h00FF, 16'h0F0F, 16, 1'b1);
    drain("t4");

    // Disabled receiver ignores a full frame and holds its outputs
    enable = 1'b0;
    send(16'h1111, 16'h2222, 16, 1'b1);
    hold(10);
    enable = 1'b1;
    check_eq("dis_hold_A", value_A, 16'h00FF);
    check_eq("dis_hold_B", value_B, 16'h0F0F);

    // Broken A pair
    tie_a = 1'b1;
    apply();
    hold(3);
    check_eq("fault_not_yet", line_fault, 0);
    hold(7);
    check_eq("fault_set", line_fault, 1);
    send(16'h3333, 16'h4444, 16, 1'b1);
    check_eq("fault_still_set", line_fault, 1);
    tie_a = 1'b0;
    apply();
    hold(3);
    check_eq("fault_clear_not_yet", line_fault, 1);
    hold(7);
    check_eq("fault_cleared", line_fault, 0);
    check_eq("fault_hold_A", value_A, 16'h00FF);
    hold(10);

    // Reset mid-frame
    send(16'hFFFF, 16'hFFFF, 9, 1'b0);
    rst = 1'b1;
    hold(3);
    rst = 1'b0;
    hold(5);
    check_eq("t6_rst_value_A", value_A, 0);
    push(1'b0, 16'h5A5A, 16'hA5A5);
    send(16'h5A5A, 16'hA5A5, 16, 1'b1);
    drain("t6");

    check_eq("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
